// File: rtl/ps2_pkg.sv
// PS/2 keyboard shared definitions: scan codes, receiver states and
// Scan Code Set 2 to character translation tables.
`timescale 1ns/1ps
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;

  localparam logic [7:0] CH_UP     = 8'h80;
  localparam logic [7:0] CH_DOWN   = 8'h81;
  localparam logic [7:0] CH_LEFT   = 8'h82;
  localparam logic [7:0] CH_RIGHT  = 8'h83;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // 00h means "no character" for an unmapped code
  function automatic logic [7:0] sc_plain(input logic [6:0] c);
    case (c)
      7'h1C: return "a";
      7'h32: return "b";
      7'h21: return "c";
      7'h23: return "d";
      7'h24: return "e";
      7'h2B: return "f";
      7'h34: return "g";
      7'h33: return "h";
      7'h43: return "i";
      7'h3B: return "j";
      7'h42: return "k";
      7'h4B: return "l";
      7'h3A: return "m";
      7'h31: return "n";
      7'h44: return "o";
      7'h4D: return "p";
      7'h15: return "q";
      7'h2D: return "r";
      7'h1B: return "s";
      7'h2C: return "t";
      7'h3C: return "u";
      7'h2A: return "v";
      7'h1D: return "w";
      7'h22: return "x";
      7'h35: return "y";
      7'h1A: return "z";
      7'h45: return "0";
      7'h16: return "1";
      7'h1E: return "2";
      7'h26: return "3";
      7'h25: return "4";
      7'h2E: return "5";
      7'h36: return "6";
      7'h3D: return "7";
      7'h3E: return "8";
      7'h46: return "9";
      7'h0E: return 8'h60;
      7'h4E: return "-";
      7'h55: return "=";
      7'h5D: return 8'h5C;
      7'h54: return "[";
      7'h5B: return "]";
      7'h4C: return ";";
      7'h52: return 8'h27;
      7'h41: return ",";
      7'h49: return ".";
      7'h4A: return "/";
      7'h29: return 8'h20;
      7'h5A: return 8'h0D;
      7'h66: return 8'h08;
      7'h0D: return 8'h09;
      7'h76: return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] sc_shift(input logic [6:0] c);
    case (c)
      7'h45: return ")";
      7'h16: return "!";
      7'h1E: return "@";
      7'h26: return "#";
      7'h25: return "$";
      7'h2E: return "%";
      7'h36: return "^";
      7'h3D: return "&";
      7'h3E: return "*";
      7'h46: return "(";
      7'h0E: return "~";
      7'h4E: return "_";
      7'h55: return "+";
      7'h5D: return "|";
      7'h54: return "{";
      7'h5B: return "}";
      7'h4C: return ":";
      7'h52: return 8'h22;
      7'h41: return "<";
      7'h49: return ">";
      7'h4A: return "?";
      default: begin
        // letters and control keys: derive from the plain table
        logic [7:0] p;
        p = sc_plain(c);
        if (p >= "a" && p <= "z") return p - 8'h20;
        return p;
      end
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 line conditioning and 11-bit frame receiver with inter-edge
// timeout; delivers one checked byte per good frame.
`timescale 1ns/1ps
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC);

  logic [1:0]    csync_q;
  logic [1:0]    dsync_q;
  logic [7:0]    hist_q;
  logic          filt_q, filt_d;
  rx_state_e     state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          bv_q, bv_d;
  logic [7:0]    byte_q, byte_d;
  logic          dat_s, fall, rise;

  assign dat_s  = dsync_q[1];
  // level flips only once 8 consecutive samples agree
  assign fall   = filt_q & (hist_q == 8'h00);
  assign rise   = ~filt_q & (hist_q == 8'hFF);
  assign filt_d = fall ? 1'b0 : (rise ? 1'b1 : filt_q);

  always_comb begin
    tmo_d = tmo_q;
    if (fall)
      tmo_d = TMO_LOAD;
    else if (state_q != RX_IDLE && tmo_q != '0)
      tmo_d = tmo_q - 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    par_ok_d = par_ok_q;
    bv_d     = 1'b0;
    byte_d   = byte_q;
    unique case (state_q)
      RX_IDLE: begin
        if (fall && !dat_s) begin
          state_d = RX_DATA;
          bit_d   = 3'd0;
        end
      end
      RX_DATA: begin
        if (fall) begin
          sh_d  = {dat_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (fall) begin
          par_ok_d = ^{sh_q, dat_s};
          state_d  = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          state_d = RX_IDLE;
          if (dat_s && par_ok_q) begin
            bv_d   = 1'b1;
            byte_d = sh_q;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
    if (state_q != RX_IDLE && !fall && tmo_q == '0)
      state_d = RX_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csync_q  <= 2'b11;
      dsync_q  <= 2'b11;
      hist_q   <= 8'hFF;
      filt_q   <= 1'b1;
      state_q  <= RX_IDLE;
      bit_q    <= 3'd0;
      sh_q     <= 8'h00;
      par_ok_q <= 1'b0;
      tmo_q    <= '0;
      bv_q     <= 1'b0;
      byte_q   <= 8'h00;
    end else begin
      csync_q  <= {csync_q[0], ps2_clk_i};
      dsync_q  <= {dsync_q[0], ps2_dat_i};
      hist_q   <= {hist_q[6:0], csync_q[1]};
      filt_q   <= filt_d;
      state_q  <= state_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      par_ok_q <= par_ok_d;
      tmo_q    <= tmo_d;
      bv_q     <= bv_d;
      byte_q   <= byte_d;
    end
  end

  assign byte_valid_o = bv_q;
  assign byte_o       = byte_q;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: frame receiver plus Set 2 decoder with
// modifier/prefix tracking and a one-cycle character strobe.
`timescale 1ns/1ps
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int CLK_HZ      = 25_000_000,
  parameter int TIMEOUT_CYC = CLK_HZ / 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       kdone,
  output logic [7:0] ascii
);

  logic       rx_valid;
  logic [7:0] rx_byte;

  ps2_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk_i       (clock),
    .rst_i       (reset),
    .ps2_clk_i   (ps2_clk),
    .ps2_dat_i   (ps2_dat),
    .byte_valid_o(rx_valid),
    .byte_o      (rx_byte)
  );

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       lsh_q, lsh_d;
  logic       rsh_q, rsh_d;
  logic       ctrl_q, ctrl_d;
  logic       caps_q, caps_d;
  logic       kdone_q, kdone_d;
  logic [7:0] ascii_q, ascii_d;
  logic [7:0] lo, hi, ch;
  logic       shift, is_let;

  always_comb begin
    shift  = lsh_q | rsh_q;
    lo     = rx_byte[7] ? 8'h00 : sc_plain(rx_byte[6:0]);
    hi     = rx_byte[7] ? 8'h00 : sc_shift(rx_byte[6:0]);
    is_let = (lo >= "a") && (lo <= "z");
    ch     = 8'h00;
    if (ext_q) begin
      case (rx_byte)
        SC_UP:    ch = CH_UP;
        SC_DOWN:  ch = CH_DOWN;
        SC_LEFT:  ch = CH_LEFT;
        SC_RIGHT: ch = CH_RIGHT;
        default:  ch = 8'h00;
      endcase
    end else if (is_let) begin
      ch = (shift ^ caps_q) ? hi : lo;
      if (ctrl_q) ch = ch & 8'h1F;
    end else begin
      ch = shift ? hi : lo;
    end
  end

  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    lsh_d   = lsh_q;
    rsh_d   = rsh_q;
    ctrl_d  = ctrl_q;
    caps_d  = caps_q;
    kdone_d = 1'b0;
    ascii_d = ascii_q;
    if (rx_valid) begin
      unique case (1'b1)
        rx_byte == SC_EXT: ext_d = 1'b1;
        rx_byte == SC_BRK: brk_d = 1'b1;
        default: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          unique case (1'b1)
            rx_byte == SC_CTRL:             ctrl_d = !brk_q;
            !ext_q && rx_byte == SC_LSHIFT: lsh_d  = !brk_q;
            !ext_q && rx_byte == SC_RSHIFT: rsh_d  = !brk_q;
            !ext_q && rx_byte == SC_CAPS: begin
              if (!brk_q) caps_d = !caps_q;
            end
            default: begin
              if (!brk_q && ch != 8'h00) begin
                kdone_d = 1'b1;
                ascii_d = ch;
              end
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      lsh_q   <= 1'b0;
      rsh_q   <= 1'b0;
      ctrl_q  <= 1'b0;
      caps_q  <= 1'b0;
      kdone_q <= 1'b0;
      ascii_q <= 8'h00;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      lsh_q   <= lsh_d;
      rsh_q   <= rsh_d;
      ctrl_q  <= ctrl_d;
      caps_q  <= caps_d;
      kdone_q <= kdone_d;
      ascii_q <= ascii_d;
    end
  end

  assign kdone = kdone_q;
  assign ascii = ascii_q;

endmodule
